// File: rtl/checkpoint_ctrl_pkg.sv
// Shared sizing and state type for the branch checkpoint controller.
// Used by checkpoint_ctrl, ckpt_tag_cam and the bench.
package checkpoint_ctrl_pkg;

    localparam int NUM_CKPT   = 4;
    localparam int TAG_W      = 5;
    localparam int CKPT_IDX_W = $clog2(NUM_CKPT);

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } ckpt_state_e;

endpackage

// File: rtl/checkpoint_ctrl_tag_cam.sv
// Tag CAM over the checkpoint slots: reports which valid slot holds the looked-up ROB tag.
// Tags of valid slots are unique, so at most one slot can hit.
module ckpt_tag_cam #(
    parameter int NUM_CKPT = checkpoint_ctrl_pkg::NUM_CKPT,
    parameter int TAG_W    = checkpoint_ctrl_pkg::TAG_W
) (
    input  logic [NUM_CKPT-1:0]            slot_valid,
    input  logic [NUM_CKPT-1:0][TAG_W-1:0] slot_tag,
    input  logic [TAG_W-1:0]               lookup_tag,
    output logic                           hit,
    output logic [$clog2(NUM_CKPT)-1:0]    hit_idx
);

    localparam int IDX_W = $clog2(NUM_CKPT);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (slot_valid[i] && (slot_tag[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/checkpoint_ctrl.sv
// Branch checkpoint slot allocator/recovery controller between rename and ROB.
// Optional CHECKPOINT_PERF_EN adds grant/flush/stall performance counters.
module checkpoint_ctrl #(
    parameter int NUM_CKPT = checkpoint_ctrl_pkg::NUM_CKPT,
    parameter int TAG_W    = checkpoint_ctrl_pkg::TAG_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic [TAG_W-1:0]            alloc_tag,
    output logic                        alloc_gnt,
    output logic [$clog2(NUM_CKPT)-1:0] alloc_slot,
    output logic                        alloc_stall,
    input  logic                        resolve_valid,
    input  logic [TAG_W-1:0]            resolve_tag,
    input  logic                        resolve_mispred,
    output logic                        resolve_ready,
    output logic                        restore_valid,
    output logic [$clog2(NUM_CKPT)-1:0] restore_slot,
    output logic [NUM_CKPT-1:0]         ckpt_valid,
    output logic                        ckpt_full
`ifdef CHECKPOINT_PERF_EN
    ,
    output logic [31:0]                 perf_alloc_cnt,
    output logic [31:0]                 perf_flush_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    import checkpoint_ctrl_pkg::*;

    localparam int IDX_W = $clog2(NUM_CKPT);

    ckpt_state_e                    state_q, state_d;
    logic [IDX_W-1:0]               head_q, head_d;
    logic [IDX_W-1:0]               tail_q, tail_d;
    logic [NUM_CKPT-1:0]            valid_q, valid_d;
    logic [NUM_CKPT-1:0][TAG_W-1:0] tag_q, tag_d;
    logic                           restore_valid_q, restore_valid_d;
    logic [IDX_W-1:0]               restore_slot_q, restore_slot_d;

    logic                           cam_hit;
    logic [IDX_W-1:0]               cam_hit_idx;
    logic                           is_idle;
    logic                           mispred_accept;
    logic                           correct_accept;
    logic [NUM_CKPT-1:0]            squash_mask;
    logic [IDX_W:0]                 squash_span;
    logic [IDX_W-1:0]               squash_off;
    logic [IDX_W-1:0]               scan_idx;
    logic                           head_found;

    ckpt_tag_cam #(
        .NUM_CKPT (NUM_CKPT),
        .TAG_W    (TAG_W)
    ) u_tag_cam (
        .slot_valid (valid_q),
        .slot_tag   (tag_q),
        .lookup_tag (resolve_tag),
        .hit        (cam_hit),
        .hit_idx    (cam_hit_idx)
    );

    assign is_idle        = (state_q == IDLE);
    assign resolve_ready  = is_idle;
    assign mispred_accept = is_idle && resolve_valid && resolve_mispred && cam_hit;
    assign correct_accept = is_idle && resolve_valid && !resolve_mispred && cam_hit;

    // An allocating branch in the same cycle as a mispredict is younger, so it is never granted.
    assign alloc_gnt   = alloc_req && is_idle && !valid_q[tail_q] && !(resolve_valid && resolve_mispred);
    assign alloc_stall = alloc_req && !alloc_gnt;
    assign alloc_slot  = tail_q;
    assign ckpt_full   = valid_q[tail_q];

    assign ckpt_valid    = valid_q;
    assign restore_valid = restore_valid_q;
    assign restore_slot  = restore_slot_q;

    // Squash range restore_slot..tail-1; equal pointers mean the ring was full, so all slots go.
    always_comb begin
        squash_span = (tail_q == restore_slot_q) ? (IDX_W+1)'(NUM_CKPT)
                                                 : {1'b0, IDX_W'(tail_q - restore_slot_q)};
        squash_mask = '0;
        squash_off  = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            squash_off     = IDX_W'(i) - restore_slot_q;
            squash_mask[i] = ({1'b0, squash_off} < squash_span);
        end
    end

    always_comb begin
        state_d         = state_q;
        tail_d          = tail_q;
        valid_d         = valid_q;
        tag_d           = tag_q;
        restore_valid_d = 1'b0;
        restore_slot_d  = restore_slot_q;

        case (state_q)
            IDLE: begin
                if (alloc_gnt) begin
                    valid_d[tail_q] = 1'b1;
                    tag_d[tail_q]   = alloc_tag;
                    tail_d          = tail_q + 1'b1;
                end
                if (correct_accept) begin
                    valid_d[cam_hit_idx] = 1'b0;
                end
                if (mispred_accept) begin
                    state_d         = RESTORE;
                    restore_valid_d = 1'b1;
                    restore_slot_d  = cam_hit_idx;
                end
            end
            RESTORE: begin
                valid_d = valid_q & ~squash_mask;
                tail_d  = restore_slot_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Head walks forward to the oldest surviving slot, never past the tail.
    always_comb begin
        head_d     = head_q;
        head_found = 1'b0;
        scan_idx   = head_q;
        for (int k = 0; k < NUM_CKPT; k++) begin
            scan_idx = head_q + IDX_W'(k);
            if (!head_found && (valid_d[scan_idx] || (scan_idx == tail_d))) begin
                head_d     = scan_idx;
                head_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            valid_q         <= '0;
            tag_q           <= '0;
            restore_valid_q <= 1'b0;
            restore_slot_q  <= '0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            restore_valid_q <= restore_valid_d;
            restore_slot_q  <= restore_slot_d;
        end
    end

`ifdef CHECKPOINT_PERF_EN
    logic [31:0] perf_alloc_q, perf_alloc_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_alloc_d = perf_alloc_q + {31'd0, alloc_gnt};
        perf_flush_d = perf_flush_q + {31'd0, mispred_accept};
        perf_stall_d = perf_stall_q + {31'd0, alloc_stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_alloc_q <= '0;
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_alloc_q <= perf_alloc_d;
            perf_flush_q <= perf_flush_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_alloc_cnt = perf_alloc_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Self-checking bench for checkpoint_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against an age-ordered list model of the live checkpoints.
module tb_checkpoint_ctrl;

    import checkpoint_ctrl_pkg::*;

    localparam int N = NUM_CKPT;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  alloc_req;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  alloc_gnt;
    logic [CKPT_IDX_W-1:0] alloc_slot;
    logic                  alloc_stall;
    logic                  resolve_valid;
    logic [TAG_W-1:0]      resolve_tag;
    logic                  resolve_mispred;
    logic                  resolve_ready;
    logic                  restore_valid;
    logic [CKPT_IDX_W-1:0] restore_slot;
    logic [N-1:0]          ckpt_valid;
    logic                  ckpt_full;

    int checks = 0;
    int errors = 0;

    // Model: live checkpoints oldest-first, each with its slot and tag.
    int live_slot[$];
    int live_tag[$];
    int mdl_tail      = 0;
    bit mdl_restoring = 1'b0;
    int mdl_rslot     = 0;
    int mdl_rpos      = 0;

    always #5 clk = ~clk;

    checkpoint_ctrl #(
        .NUM_CKPT (N),
        .TAG_W    (TAG_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_tag       (alloc_tag),
        .alloc_gnt       (alloc_gnt),
        .alloc_slot      (alloc_slot),
        .alloc_stall     (alloc_stall),
        .resolve_valid   (resolve_valid),
        .resolve_tag     (resolve_tag),
        .resolve_mispred (resolve_mispred),
        .resolve_ready   (resolve_ready),
        .restore_valid   (restore_valid),
        .restore_slot    (restore_slot),
        .ckpt_valid      (ckpt_valid),
        .ckpt_full       (ckpt_full)
    );

    function automatic bit slotLive(int s);
        foreach (live_slot[i]) if (live_slot[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int findTag(int t);
        foreach (live_tag[i]) if (live_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic bit expGrant();
        return alloc_req && !mdl_restoring && !slotLive(mdl_tail) && !(resolve_valid && resolve_mispred);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input int ar, input int at, input int rv, input int rt, input int rm);
        reset           = (r != 0);
        alloc_req       = (ar != 0);
        alloc_tag       = TAG_W'(at);
        resolve_valid   = (rv != 0);
        resolve_tag     = TAG_W'(rt);
        resolve_mispred = (rm != 0);
    endtask

    task automatic checkOutput();
        logic [N-1:0] ev;
        bit           g;
        ev = '0;
        foreach (live_slot[i]) ev[live_slot[i]] = 1'b1;
        g = expGrant();
        cmp("ckpt_valid",    32'(ckpt_valid),    32'(ev));
        cmp("ckpt_full",     32'(ckpt_full),     32'(slotLive(mdl_tail)));
        cmp("alloc_slot",    32'(alloc_slot),    32'(mdl_tail));
        cmp("alloc_gnt",     32'(alloc_gnt),     32'(g));
        cmp("alloc_stall",   32'(alloc_stall),   32'(alloc_req && !g));
        cmp("resolve_ready", 32'(resolve_ready), 32'(!mdl_restoring));
        cmp("restore_valid", 32'(restore_valid), 32'(mdl_restoring));
        cmp("restore_slot",  32'(restore_slot),  32'(mdl_rslot));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit g;
        int hit;
        g = expGrant();
        if (reset) begin
            live_slot.delete();
            live_tag.delete();
            mdl_tail      = 0;
            mdl_restoring = 1'b0;
            mdl_rslot     = 0;
            return;
        end
        if (mdl_restoring) begin
            while (live_slot.size() > mdl_rpos) begin
                void'(live_slot.pop_back());
                void'(live_tag.pop_back());
            end
            mdl_tail      = mdl_rslot;
            mdl_restoring = 1'b0;
            return;
        end
        hit = resolve_valid ? findTag(int'(resolve_tag)) : -1;
        if (hit >= 0 && resolve_mispred) begin
            mdl_restoring = 1'b1;
            mdl_rslot     = live_slot[hit];
            mdl_rpos      = hit;
        end else if (hit >= 0) begin
            live_slot.delete(hit);
            live_tag.delete(hit);
        end
        if (g) begin
            live_slot.push_back(mdl_tail);
            live_tag.push_back(int'(alloc_tag));
            mdl_tail = (mdl_tail + 1) % N;
        end
    endtask

    task automatic runCycle(input int r, input int ar, input int at, input int rv, input int rt, input int rm);
        @(negedge clk);
        applyStimulus(r, ar, at, rv, rt, rm);
        #1;
        checkOutput();
        modelStep();
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Reset state
        runCycle(0, 0, 0, 0, 0, 0);
        cmp("lit_reset_valid", 32'(ckpt_valid), 32'd0);
        cmp("lit_reset_slot", 32'(alloc_slot), 32'd0);
        cmp("lit_reset_ready", 32'(resolve_ready), 32'd1);

        // Fill all four slots, then stall
        for (int t = 1; t <= 4; t++) begin
            runCycle(0, 1, t, 0, 0, 0);
            cmp("lit_fill_gnt", 32'(alloc_gnt), 32'd1);
            cmp("lit_fill_slot", 32'(alloc_slot), 32'(t - 1));
        end
        runCycle(0, 1, 5, 0, 0, 0);
        cmp("lit_full", 32'(ckpt_full), 32'd1);
        cmp("lit_full_stall", 32'(alloc_stall), 32'd1);
        cmp("lit_full_valid", 32'(ckpt_valid), 32'hF);
        runCycle(0, 1, 5, 1, 1, 0);
        cmp("lit_free_same_cycle_stall", 32'(alloc_stall), 32'd1);
        runCycle(0, 1, 5, 0, 0, 0);
        cmp("lit_freed_valid", 32'(ckpt_valid), 32'b1110);
        cmp("lit_freed_gnt", 32'(alloc_gnt), 32'd1);
        cmp("lit_freed_slot", 32'(alloc_slot), 32'd0);
        runCycle(0, 0, 0, 0, 0, 0);
        cmp("lit_refilled", 32'(ckpt_valid), 32'hF);

        // Mispredict tag 2 with slots 0..3 holding tags 1..4
        runCycle(1, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 4; t++) runCycle(0, 1, t, 0, 0, 0);
        runCycle(0, 1, 9, 1, 2, 1);
        cmp("lit_mispred_alloc_gnt", 32'(alloc_gnt), 32'd0);
        runCycle(0, 0, 0, 1, 1, 0);
        cmp("lit_restore_valid", 32'(restore_valid), 32'd1);
        cmp("lit_restore_slot", 32'(restore_slot), 32'd1);
        cmp("lit_restore_ready", 32'(resolve_ready), 32'd0);
        runCycle(0, 0, 0, 0, 0, 0);
        cmp("lit_after_restore_valid", 32'(ckpt_valid), 32'b0001);
        cmp("lit_after_restore_tail", 32'(alloc_slot), 32'd1);
        cmp("lit_after_restore_rv", 32'(restore_valid), 32'd0);

        // Mispredict with no matching tag
        runCycle(0, 0, 0, 1, 7, 1);
        runCycle(0, 0, 0, 0, 0, 0);
        cmp("lit_nohit_valid", 32'(ckpt_valid), 32'b0001);
        cmp("lit_nohit_rv", 32'(restore_valid), 32'd0);

        // Reset while restoring
        runCycle(0, 1, 2, 0, 0, 0);
        runCycle(0, 0, 0, 1, 1, 1);
        runCycle(1, 0, 0, 0, 0, 0);
        cmp("lit_rst_restore_rv", 32'(restore_valid), 32'd1);
        cmp("lit_rst_restore_slot", 32'(restore_slot), 32'd0);
        runCycle(0, 0, 0, 0, 0, 0);
        cmp("lit_rst_after_rv", 32'(restore_valid), 32'd0);
        cmp("lit_rst_after_valid", 32'(ckpt_valid), 32'd0);

        // Wrap: allocate then free ten branches in order
        for (int i = 0; i < 10; i++) begin
            runCycle(0, 1, 10 + i, 0, 0, 0);
            cmp("lit_wrap_gnt", 32'(alloc_gnt), 32'd1);
            cmp("lit_wrap_slot", 32'(alloc_slot), 32'(i % N));
            runCycle(0, 0, 0, 1, 10 + i, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r, ar, at, rv, rt, rm, tries;
            r  = ($urandom_range(99) == 0) ? 1 : 0;
            ar = ($urandom_range(99) < 60) ? 1 : 0;
            at = int'($urandom_range((1 << TAG_W) - 1));
            tries = 0;
            while (findTag(at) >= 0 && tries < 100) begin
                at = int'($urandom_range((1 << TAG_W) - 1));
                tries++;
            end
            if (findTag(at) >= 0) ar = 0;
            rv = ($urandom_range(99) < 40) ? 1 : 0;
            rm = ($urandom_range(99) < 25) ? 1 : 0;
            if (live_tag.size() > 0 && $urandom_range(99) < 80)
                rt = live_tag[$urandom_range(live_tag.size() - 1)];
            else
                rt = int'($urandom_range((1 << TAG_W) - 1));
            runCycle(r, ar, at, rv, rt, rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
